// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: bus layouts, bus widths and load_sel bit positions.
package mem_stage_pkg;

    localparam int unsigned LdSelB  = 0;
    localparam int unsigned LdSelBu = 1;
    localparam int unsigned LdSelH  = 2;
    localparam int unsigned LdSelHu = 3;
    localparam int unsigned LdSelW  = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] final_result;
        logic [4:0]  dest;
        logic        gr_we;
        logic        res_from_mem;
        logic [4:0]  load_sel;
        logic        mul_op;
        logic        mul_horl;
        logic        csr_read;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        ertn;
        logic [7:0]  ex_gather;
        logic [4:0]  tlb_op;
        logic [31:0] vaddr;
        logic        mem_req;
    } es_to_ms_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] final_value;
        logic [4:0]  dest;
        logic        gr_we;
        logic        csr_read;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        ertn;
        logic [7:0]  ex_gather;
        logic [4:0]  tlb_op;
        logic [31:0] vaddr;
    } ms_to_ws_t;

    // Field order fixes the bit offsets seen by decode (pending is the MSB).
    typedef struct packed {
        logic        pending;
        logic        csr_read;
        logic        wr_valid;
        logic [4:0]  dest;
        logic [31:0] value;
    } ms_rel_t;

    localparam int unsigned ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
    localparam int unsigned MS_TO_WS_BUS_WD = $bits(ms_to_ws_t);
    localparam int unsigned MS_REL_BUS_WD   = $bits(ms_rel_t);

endpackage

// File: rtl/mem_rdata_fifo.sv
// Two-entry in-order buffer for data-SRAM read responses.
module mem_rdata_fifo (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        empty,
    output logic        full
);

    logic [31:0] mem_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic        do_push;
    logic        do_pop;

    assign empty   = (cnt_q == 2'd0);
    assign full    = (cnt_q == 2'd2);
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: tracks outstanding SRAM requests, buffers responses in order,
// drops responses of flushed instructions, and produces the write-back value.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_req,
    input  logic                       data_sram_addr_ok,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic [63:0]                es_mul_result,
    output logic                       ms_mem_full,
    output logic [MS_REL_BUS_WD-1:0]   ms_related_bus,
    output logic                       ms_ex,
    input  logic                       ws_ex
);

    es_to_ms_t es_bus;
    es_to_ms_t bus_r;
    ms_to_ws_t ws_bus;
    ms_rel_t   rel_bus;

    logic        ms_valid_q;
    logic [1:0]  out_cnt_q, out_cnt_d;
    logic [1:0]  disc_cnt_q, disc_cnt_d;
    logic        req_acc;
    logic        fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [31:0] fifo_head;
    logic        ms_ready_go;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] final_value;

    assign es_bus  = es_to_ms_bus;
    assign req_acc = data_sram_req & data_sram_addr_ok;

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (req_acc && !data_sram_data_ok) begin
            out_cnt_d = out_cnt_q + 2'd1;
        end else if (!req_acc && data_sram_data_ok) begin
            out_cnt_d = out_cnt_q - 2'd1;
        end
        // On flush every response still owed (including one accepted this cycle) is stale.
        disc_cnt_d = disc_cnt_q;
        if (ws_ex) begin
            disc_cnt_d = out_cnt_d;
        end else if (data_sram_data_ok && disc_cnt_q != 2'd0) begin
            disc_cnt_d = disc_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q <= 1'b0;
            out_cnt_q  <= 2'd0;
            disc_cnt_q <= 2'd0;
            bus_r      <= '0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            disc_cnt_q <= disc_cnt_d;
            if (ws_ex) begin
                ms_valid_q <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid_q <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allowin) begin
                bus_r <= es_bus;
            end
        end
    end

    assign fifo_push = data_sram_data_ok & (disc_cnt_q == 2'd0) & ~ws_ex;
    assign fifo_pop  = ms_valid_q & bus_r.mem_req & ws_allowin & ms_ready_go;

    mem_rdata_fifo u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (ws_ex),
        .push      (fifo_push),
        .push_data (data_sram_rdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign ms_ready_go    = ~(bus_r.mem_req & fifo_empty);
    assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~ws_ex;
    assign ms_mem_full    = (out_cnt_q == 2'd2);
    assign ms_ex          = ms_valid_q & ((|bus_r.ex_gather) | bus_r.ertn);

    assign off = bus_r.final_result[1:0];

    always_comb begin
        case (off)
            2'd0:    ld_byte = fifo_head[7:0];
            2'd1:    ld_byte = fifo_head[15:8];
            2'd2:    ld_byte = fifo_head[23:16];
            default: ld_byte = fifo_head[31:24];
        endcase
        ld_half   = off[1] ? fifo_head[31:16] : fifo_head[15:0];
        load_data = fifo_head;
        if (bus_r.load_sel[LdSelB]) begin
            load_data = {{24{ld_byte[7]}}, ld_byte};
        end else if (bus_r.load_sel[LdSelBu]) begin
            load_data = {24'd0, ld_byte};
        end else if (bus_r.load_sel[LdSelH]) begin
            load_data = {{16{ld_half[15]}}, ld_half};
        end else if (bus_r.load_sel[LdSelHu]) begin
            load_data = {16'd0, ld_half};
        end
    end

    always_comb begin
        final_value = bus_r.final_result;
        if (bus_r.res_from_mem) begin
            final_value = load_data;
        end else if (bus_r.mul_op) begin
            final_value = bus_r.mul_horl ? es_mul_result[63:32] : es_mul_result[31:0];
        end
    end

    always_comb begin
        ws_bus             = '0;
        ws_bus.pc          = bus_r.pc;
        ws_bus.final_value = final_value;
        ws_bus.dest        = bus_r.dest;
        ws_bus.gr_we       = bus_r.gr_we;
        ws_bus.csr_read    = bus_r.csr_read;
        ws_bus.csr_we      = bus_r.csr_we;
        ws_bus.csr_num     = bus_r.csr_num;
        ws_bus.csr_wmask   = bus_r.csr_wmask;
        ws_bus.csr_wvalue  = bus_r.csr_wvalue;
        ws_bus.ertn        = bus_r.ertn;
        ws_bus.ex_gather   = bus_r.ex_gather;
        ws_bus.tlb_op      = bus_r.tlb_op;
        ws_bus.vaddr       = bus_r.vaddr;

        rel_bus          = '0;
        rel_bus.pending  = ms_valid_q & bus_r.mem_req & fifo_empty;
        rel_bus.csr_read = ms_valid_q & bus_r.csr_read;
        rel_bus.wr_valid = ms_valid_q & bus_r.gr_we;
        rel_bus.dest     = bus_r.dest;
        rel_bus.value    = final_value;
    end

    assign ms_to_ws_bus   = ws_bus;
    assign ms_related_bus = rel_bus;

    // FIFO overflow is excluded by ms_mem_full throttling the exe stage.
    assert property (@(posedge clk) disable iff (!resetn) !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected write-back values, a monitor pops them.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                       clk;
    logic                       resetn;
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       data_sram_req;
    logic                       data_sram_addr_ok;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic [63:0]                es_mul_result;
    logic                       ms_mem_full;
    logic [MS_REL_BUS_WD-1:0]   ms_related_bus;
    logic                       ms_ex;
    logic                       ws_ex;

    ms_to_ws_t out;
    ms_rel_t   rel;
    assign out = ms_to_ws_bus;
    assign rel = ms_related_bus;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_req     (data_sram_req),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .es_mul_result     (es_mul_result),
        .ms_mem_full       (ms_mem_full),
        .ms_related_bus    (ms_related_bus),
        .ms_ex             (ms_ex),
        .ws_ex             (ws_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output must match the oldest expected entry.
    always @(negedge clk) begin
        if (resetn && ms_to_ws_valid && ws_allowin) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got pc %h value %h want none", out.pc,
                         out.final_value);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_pc", out.pc, e.pc);
                check("out_value", out.final_value, e.value);
            end
        end
    end

    function automatic es_to_ms_t mk(input logic [31:0] pc, input logic [31:0] res,
                                     input logic [4:0] sel, input logic from_mem,
                                     input logic mem_req, input logic mul_op,
                                     input logic horl);
        es_to_ms_t b;
        b              = '0;
        b.pc           = pc;
        b.final_result = res;
        b.vaddr        = res;
        b.dest         = 5'd4;
        b.gr_we        = 1'b1;
        b.load_sel     = sel;
        b.res_from_mem = from_mem;
        b.mem_req      = mem_req;
        b.mul_op       = mul_op;
        b.mul_horl     = horl;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand one instruction to the stage; its SRAM request (if any) is accepted on entry.
    task automatic send(input es_to_ms_t b, input logic req, input logic expect_out,
                        input logic [31:0] exp_value);
        int n;
        n = 0;
        while (!ms_allowin && n < 20) begin
            tick();
            n++;
        end
        if (!ms_allowin) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got allowin 0 want 1 for pc %h", b.pc);
        end
        if (expect_out) sb.push_back('{pc: b.pc, value: exp_value});
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = b;
        data_sram_req     = req;
        data_sram_addr_ok = req;
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_req     = 1'b0;
        data_sram_addr_ok = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = d;
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        es_to_ms_t b;
        resetn            = 1'b0;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_req     = 1'b0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        es_mul_result     = 64'h0000_0001_0000_0002;
        ws_ex             = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        #1;

        check("rst_valid", 32'(ms_to_ws_valid), 32'd0);
        check("rst_allowin", 32'(ms_allowin), 32'd1);
        check("rst_mem_full", 32'(ms_mem_full), 32'd0);
        check("rst_ms_ex", 32'(ms_ex), 32'd0);
        check("rst_rel_valid", 32'(rel.wr_valid), 32'd0);
        check("rst_rel_pending", 32'(rel.pending), 32'd0);

        // ld.b at 0x1003, response two cycles after entry.
        send(mk(32'h100, 32'h1003, 5'b00001, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1,
             32'hFFFF_FF80);
        check("ldb_pending", 32'(rel.pending), 32'd1);
        check("ldb_wait_valid", 32'(ms_to_ws_valid), 32'd0);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_0000;
        #1;
        check("ldb_no_comb_path", 32'(ms_to_ws_valid), 32'd0);
        @(posedge clk);
        #1;
        data_sram_data_ok = 1'b0;
        check("ldb_valid_t1", 32'(ms_to_ws_valid), 32'd1);
        tick();

        send(mk(32'h104, 32'h2002, 5'b01000, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1,
             32'h0000_BEEF);
        respond(32'hBEEF_1234);
        send(mk(32'h108, 32'h2002, 5'b00100, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1,
             32'hFFFF_BEEF);
        respond(32'hBEEF_1234);

        // Multiplier halves.
        send(mk(32'h10C, 32'h0, 5'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0, 1'b1, 32'h0000_0001);
        send(mk(32'h110, 32'h0, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0, 1'b1, 32'h0000_0002);

        // Store waits for its response; value is the ALU result.
        send(mk(32'h114, 32'h3000, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1, 32'h0000_3000);
        check("store_pending", 32'(rel.pending), 32'd1);
        respond(32'h0);
        tick();

        // Exception marker and forwarding fields.
        b      = mk(32'h118, 32'h1234, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        b.ertn = 1'b1;
        b.dest = 5'd3;
        send(b, 1'b0, 1'b1, 32'h1234);
        check("ertn_ms_ex", 32'(ms_ex), 32'd1);
        check("rel_wr_valid", 32'(rel.wr_valid), 32'd1);
        check("rel_dest", 32'(rel.dest), 32'd3);
        check("rel_value", rel.value, 32'h1234);
        tick();
        check("ms_ex_clear", 32'(ms_ex), 32'd0);

        // Two loads stalled by write-back: both responses buffered, then retire in order.
        ws_allowin = 1'b0;
        send(mk(32'h200, 32'h4000, 5'b10000, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1, 32'hA);
        sb.push_back('{pc: 32'h204, value: 32'hB});
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk(32'h204, 32'h4004, 5'b10000, 1'b1, 1'b1, 1'b0, 1'b0);
        data_sram_req     = 1'b1;
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_req     = 1'b0;
        data_sram_addr_ok = 1'b0;
        check("stall_mem_full", 32'(ms_mem_full), 32'd1);
        check("stall_allowin", 32'(ms_allowin), 32'd0);
        respond(32'hA);
        respond(32'hB);
        check("stall_valid", 32'(ms_to_ws_valid), 32'd1);
        check("stall_full_drop", 32'(ms_mem_full), 32'd0);
        ws_allowin = 1'b1;
        tick();
        es_to_ms_valid = 1'b0;
        tick();
        tick();

        // Flush with two responses outstanding: both are dropped.
        send(mk(32'h300, 32'h5000, 5'b10000, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 32'h0);
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk(32'h304, 32'h5004, 5'b10000, 1'b1, 1'b1, 1'b0, 1'b0);
        data_sram_req     = 1'b1;
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_req     = 1'b0;
        data_sram_addr_ok = 1'b0;
        es_to_ms_valid    = 1'b0;
        check("flush_pre_full", 32'(ms_mem_full), 32'd1);
        ws_ex = 1'b1;
        #1;
        check("flush_valid_mask", 32'(ms_to_ws_valid), 32'd0);
        @(posedge clk);
        #1;
        ws_ex = 1'b0;
        check("flush_allowin", 32'(ms_allowin), 32'd1);
        check("flush_mem_full", 32'(ms_mem_full), 32'd1);
        respond(32'hDEAD_0001);
        check("flush_full_after1", 32'(ms_mem_full), 32'd0);
        send(mk(32'h500, 32'h6000, 5'b10000, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1, 32'h55);
        respond(32'hDEAD_0002);
        #1;
        check("flush_drop2_pending", 32'(rel.pending), 32'd1);
        respond(32'h55);
        tick();

        // Flush coincident with the only response.
        send(mk(32'h600, 32'h7000, 5'b10000, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 32'h0);
        ws_ex             = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h66;
        tick();
        ws_ex             = 1'b0;
        data_sram_data_ok = 1'b0;
        check("exok_valid", 32'(ms_to_ws_valid), 32'd0);
        check("exok_allowin", 32'(ms_allowin), 32'd1);
        check("exok_mem_full", 32'(ms_mem_full), 32'd0);
        check("exok_pending", 32'(rel.pending), 32'd0);
        send(mk(32'h700, 32'h8000, 5'b10000, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1, 32'h77);
        check("exok_next_pending", 32'(rel.pending), 32'd1);
        respond(32'h77);
        repeat (3) tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between `exe_stage` and `wb_stage`. It owns the data-SRAM response side: it tracks outstanding requests issued by `exe_stage`, buffers read data in order, and drops responses that belong to flushed instructions. It also aligns and extends load data, selects the multiplier half, and passes exceptions and CSR fields to write-back. It drives forwarding and hazard information back to decode.

## Interface
Parameters: none. Bus widths come from the shared header (`ES_TO_MS_BUS_WD`, `MS_TO_WS_BUS_WD`, `MS_REL_BUS_WD`).
- clk  in  1  clock; single clock domain
- resetn  in  1  synchronous, active-low reset
- ws_allowin  in  1  wb stage can accept
- ms_allowin  out  1  this stage can accept
- es_to_ms_valid  in  1  exe output valid
- es_to_ms_bus  in  `ES_TO_MS_BUS_WD`  exe payload: pc, final result, dest, gr_we, res_from_mem, load_sel[4:0], mul_op, mul_horl, CSR fields, ertn, ex_gather, tlb_op, vaddr, mem_req
- ms_to_ws_valid  out  1  payload valid to wb
- ms_to_ws_bus  out  `MS_TO_WS_BUS_WD`  pc, final value, dest, gr_we, CSR fields, ertn, ex_gather, tlb_op, vaddr
- data_sram_req  in  1  exe request strobe (observed)
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  response valid
- data_sram_rdata  in  32  response data
- es_mul_result  in  64  wallace product, aligned with this stage
- ms_mem_full  out  1  two responses outstanding; exe must not raise data_sram_req
- ms_related_bus  out  `MS_REL_BUS_WD`  {pending, csr_read, valid&gr_we, dest[4:0], value[31:0]}
- ms_ex  out  1  exception or ertn present in this stage
- ws_ex  in  1  flush from wb

## Operation
- Pipeline register: `ms_valid` and `bus_r`.
  - `ms_valid` clears on reset or on `ws_ex`.
  - Otherwise, when `ms_allowin` is high, `ms_valid` loads `es_to_ms_valid`.
  - `bus_r` loads when `es_to_ms_valid & ms_allowin`.
- Outstanding counter `out_cnt` (2 bits, 0..2):
  - +1 on `data_sram_req & data_sram_addr_ok`.
  - −1 on `data_sram_data_ok`.
  - Both in the same cycle: no change.
  - `ms_mem_full = (out_cnt == 2)`.
- Discard counter `disc_cnt` (2 bits):
  - On `ws_ex`, load with `out_cnt` minus 1 if `data_ok` is high that cycle, plus 1 if `req & addr_ok` is high that cycle. The new request belongs to the flushed path.
  - Otherwise, `data_ok` with `disc_cnt != 0` decrements it and drops the data.
- Read FIFO: 2 entries × 32 bits, in order.
  - Push on `data_ok & disc_cnt == 0 & ~ws_ex`.
  - Pop when `ms_valid & mem_req & ws_allowin & ms_ready_go`.
  - Cleared on `ws_ex` and on reset.
  - Push and pop in the same cycle are legal.
  - A push when the FIFO is full is a protocol violation; `ms_mem_full` prevents it.
- Ready and valid:
  - `ms_ready_go = ~(mem_req & fifo_empty)`.
  - `ms_allowin = ~ms_valid | ms_ready_go & ws_allowin`.
  - `ms_to_ws_valid = ms_valid & ms_ready_go & ~ws_ex`.
- Load data: `word = fifo_head`, `off = final_result[1:0]`.
  - load_sel[0] ld.b: sign-extend byte `off`.
  - load_sel[1] ld.bu: zero-extend byte `off`.
  - load_sel[2] ld.h: sign-extend half `off[1]`.
  - load_sel[3] ld.hu: zero-extend half `off[1]`.
  - load_sel[4] ld.w: full word.
- Final value priority: `res_from_mem` → load data; `mul_op` → `mul_horl ? es_mul_result[63:32] : [31:0]`; otherwise `bus_r` final result.
- `ms_ex = ms_valid & (|ex_gather | ertn)`.
- Stores with `mem_req` also wait for `data_ok`; their FIFO entry is popped and ignored.
- `ms_related_bus.pending = ms_valid & mem_req & fifo_empty`. Decode stalls on pending.

## Timing
- Reset values: `ms_valid`=0, `out_cnt`=0, `disc_cnt`=0, FIFO empty.
  - Hence `ms_to_ws_valid`=0, `ms_allowin`=1, `ms_mem_full`=0, `ms_ex`=0, and the related-bus valid and pending bits are 0.
- Latency with `data_ok` already buffered: 1 cycle in stage.
- Latency with `data_ok` arriving at cycle t while waiting: `ms_to_ws_valid` rises at t+1. There is no combinational path from `data_ok` to `ms_to_ws_valid`.
- `ws_ex` takes priority over everything: valid, FIFO and discard are updated in the same edge, and any `data_ok` that cycle is discarded.
- Reset mid-transaction clears all counters. The memory side is reset together with the core.

## Structure
- Shared header `mycpu.h` holds:
  - bus widths;
  - the `load_sel` bit positions;
  - the related-bus field offsets.
- Sub-module `mem_rdata_fifo` (2-entry, in-order, with push, pop, clear, empty and full) is natural.
- The load-extension logic stays inline.

## Test plan
- ld.b at address 0x1003, rdata 0x80FF_0000, `data_ok` 2 cycles after entry → value 0xFFFF_FF80, `ms_to_ws_valid` one cycle after `data_ok`.
- ld.hu at offset 2, rdata 0xBEEF_1234 → 0x0000_BEEF; ld.h with the same inputs → 0xFFFF_BEEF.
- mul with `mul_horl`=1 and `es_mul_result`=0x0000_0001_0000_0002 → 0x0000_0001; with `mul_horl`=0 → 0x0000_0002.
- Two back-to-back loads with `ws_allowin`=0 and responses 0xA, 0xB → FIFO full, `ms_mem_full` asserted; on release the two loads retire in order with 0xA then 0xB.
- `ws_ex` while `out_cnt`=2 and no `data_ok` → `disc_cnt`=2; the next two responses are dropped; the third load after the flush receives its own data.
- `ws_ex` in the same cycle as `data_ok` with `out_cnt`=1 → `disc_cnt`=0, FIFO empty, `ms_valid`=0 next cycle.
